// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift-unit arbiter.
//   arb_state_t : arbiter FSM states (IDLE / EXEC / RESP)
//   sh_req_t    : one requester's shifter operands bundled together
//   FUNC_RRX    : function select for shift-by-1 through carry
//   WIDTH/DIST_W: operand and distance widths of the shared shifter
//   onehot2()   : requester index -> 2-bit one-hot select
package shift_arb_pkg;

  localparam int WIDTH  = 32;
  localparam int DIST_W = 5;

  localparam logic [1:0] FUNC_RRX = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  operand;
    logic [DIST_W-1:0] distance;
    logic [1:0]        func;
    logic              cin;
  } sh_req_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with priority pointer.
//   clk, rst      : clock, asynchronous active-high reset
//   req[1:0]      : raw request valids
//   mask[1:0]     : eligibility mask (owner-only while a lock is held)
//   accept        : the current grant is being taken this cycle
//   ptr_load      : overwrite the pointer with ptr_load_val
//   gnt[1:0]      : one-hot grant among eligible requesters
//   gnt_id        : index of the granted requester
//   any_gnt       : at least one eligible requester
// The pointer only moves on contention: the winner is the pointer requester
// and the pointer flips to the loser. A lone requester does not move it.
import shift_arb_pkg::*;

module rr_arb2 #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       accept,
  input  logic       ptr_load,
  input  logic       ptr_load_val,
  output logic [1:0] gnt,
  output logic       gnt_id,
  output logic       any_gnt
);

  logic       ptr_q;
  logic [1:0] req_eff;

  assign req_eff = req & mask;

  always_comb begin
    gnt_id = 1'b0;
    case (req_eff)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr_q;
      default: gnt_id = 1'b0;
    endcase
  end

  assign any_gnt = |req_eff;
  assign gnt     = any_gnt ? onehot2(gnt_id) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= RR_INIT;
    end else if (ptr_load) begin
      ptr_q <= ptr_load_val;
    end else if (accept && (&req_eff)) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one external right-shift datapath between two requesters
// (0 = execute stage, 1 = address/immediate unit).
//   CLK, RESET            : clock, asynchronous active-high reset
//   REQn_VALID/READY      : request handshake, READY only in IDLE
//   REQn_OPERAND/DISTANCE/FUNC/CIN : operands forwarded to the shifter
//   REQn_LOCK             : keep the grant for the next op
//   RSPn_VALID/READY      : response handshake for requester n
//   RSP_RESULT, RSP_COUT  : captured shifter result, shared by both channels
//   SH_OP_IN/DISTANCE/FUNC_SEL/CIN : registered shifter inputs
//   SH_RESULT, SH_COUT    : combinational shifter outputs
// Optional feature macro: SHIFT_ARB_LOCK_EN enables grant locking with a
// LOCK_MAX consecutive-grant limit; without it REQn_LOCK is ignored.
import shift_arb_pkg::*;

module shift_unit_arbiter #(
  parameter logic RR_INIT  = 1'b0,
  parameter int   LOCK_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [WIDTH-1:0]  REQ0_OPERAND,
  input  logic [DIST_W-1:0] REQ0_DISTANCE,
  input  logic [1:0]        REQ0_FUNC,
  input  logic              REQ0_CIN,
  input  logic              REQ0_LOCK,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [WIDTH-1:0]  REQ1_OPERAND,
  input  logic [DIST_W-1:0] REQ1_DISTANCE,
  input  logic [1:0]        REQ1_FUNC,
  input  logic              REQ1_CIN,
  input  logic              REQ1_LOCK,
  output logic              RSP0_VALID,
  input  logic              RSP0_READY,
  output logic              RSP1_VALID,
  input  logic              RSP1_READY,
  output logic [WIDTH-1:0]  RSP_RESULT,
  output logic              RSP_COUT,
  output logic [WIDTH-1:0]  SH_OP_IN,
  output logic [DIST_W-1:0] SH_DISTANCE,
  output logic [1:0]        SH_FUNC_SEL,
  output logic              SH_CIN,
  input  logic [WIDTH-1:0]  SH_RESULT,
  input  logic              SH_COUT
);

  arb_state_t state_q, state_d;

  sh_req_t    req0_f, req1_f, req_sel, sh_p0;
  logic       owner_p0;
  logic [WIDTH-1:0] result_p1;
  logic       cout_p1;
  logic [1:0] vld_p1;

  logic [1:0] arb_req, arb_mask, gnt;
  logic       gnt_id, any_gnt;
  logic       accept, rsp_done, owner_rsp_ready;
  logic       ptr_load, ptr_load_val;

  assign req0_f  = {REQ0_OPERAND, REQ0_DISTANCE, REQ0_FUNC, REQ0_CIN};
  assign req1_f  = {REQ1_OPERAND, REQ1_DISTANCE, REQ1_FUNC, REQ1_CIN};
  assign req_sel = gnt_id ? req1_f : req0_f;
  assign arb_req = {REQ1_VALID, REQ0_VALID};

  assign owner_rsp_ready = owner_p0 ? RSP1_READY : RSP0_READY;

  rr_arb2 #(.RR_INIT(RR_INIT)) u_rr_arb2 (
    .clk          (CLK),
    .rst          (RESET),
    .req          (arb_req),
    .mask         (arb_mask),
    .accept       (accept),
    .ptr_load     (ptr_load),
    .ptr_load_val (ptr_load_val),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .any_gnt      (any_gnt)
  );

  // FSM: state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. READY is forced low while RESET is held so every output
  // reads 0 during reset, even with a requester already valid.
  always_comb begin
    accept     = (state_q == IDLE) && any_gnt && !RESET;
    REQ0_READY = accept && gnt[0];
    REQ1_READY = accept && gnt[1];
    rsp_done   = (state_q == RESP) && owner_rsp_ready;
  end

  // Stage p0: granted operands registered into the shifter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sh_p0    <= '0;
      owner_p0 <= 1'b0;
    end else if (accept) begin
      sh_p0    <= req_sel;
      owner_p0 <= gnt_id;
    end
  end

  assign SH_OP_IN    = sh_p0.operand;
  assign SH_DISTANCE = sh_p0.distance;
  assign SH_FUNC_SEL = sh_p0.func;
  assign SH_CIN      = sh_p0.cin;

  // Stage p1: shifter result captured and held until the owner consumes it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      result_p1 <= '0;
      cout_p1   <= 1'b0;
      vld_p1    <= 2'b00;
    end else if (state_q == EXEC) begin
      result_p1 <= SH_RESULT;
      cout_p1   <= SH_COUT;
      vld_p1    <= onehot2(owner_p0);
    end else if (rsp_done) begin
      vld_p1    <= 2'b00;
    end
  end

  assign RSP_RESULT = result_p1;
  assign RSP_COUT   = cout_p1;
  assign RSP0_VALID = vld_p1[0];
  assign RSP1_VALID = vld_p1[1];

`ifdef SHIFT_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             locked_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic             owner_valid, owner_lock, lock_hold, lock_forced;

  assign owner_valid = owner_p0 ? REQ1_VALID : REQ0_VALID;
  assign owner_lock  = owner_p0 ? REQ1_LOCK  : REQ0_LOCK;

  // The lock only binds while the owner keeps requesting; an idle owner
  // releases it in the same cycle so the other side can be granted at once.
  assign lock_hold   = locked_q && owner_valid;
  assign arb_mask    = lock_hold ? onehot2(owner_p0) : 2'b11;

  // lock_cnt_q counts consecutive grants to the owner, first grant included.
  assign lock_forced  = rsp_done && owner_lock && (lock_cnt_q >= CNT_W'(LOCK_MAX));
  assign ptr_load     = lock_forced;
  assign ptr_load_val = ~owner_p0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else if (accept) begin
      locked_q   <= lock_hold;
      lock_cnt_q <= lock_hold ? lock_cnt_q + 1'b1 : CNT_W'(1);
    end else if (rsp_done) begin
      if (owner_lock && (lock_cnt_q < CNT_W'(LOCK_MAX))) begin
        locked_q <= 1'b1;
      end else begin
        locked_q   <= 1'b0;
        lock_cnt_q <= '0;
      end
    end else if ((state_q == IDLE) && locked_q && !owner_valid) begin
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end
  end
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;

  assign unused_lock  = ^{REQ0_LOCK, REQ1_LOCK};
  assign arb_mask     = 2'b11;
  assign ptr_load     = 1'b0;
  assign ptr_load_val = 1'b0;
`endif

`ifndef SYNTHESIS
  // Requesters must hold VALID and operands steady until accepted.
  a_req0_hold: assert property (@(posedge CLK) disable iff (RESET)
    (REQ0_VALID && !REQ0_READY) |=> (REQ0_VALID && $stable(req0_f)));
  a_req1_hold: assert property (@(posedge CLK) disable iff (RESET)
    (REQ1_VALID && !REQ1_READY) |=> (REQ1_VALID && $stable(req1_f)));
`endif

endmodule
